uart_word_tx: RTL

Parametrised UART transmitter that accepts a WORD_WIDTH-bit word over a valid/ready handshake and serialises it on `tx` as WORD_WIDTH/8 consecutive UART frames, least-significant byte first. It sits between the 32-bit data path and the pad. Bit timing comes from an external baud generator's single-cycle `baud_tick` strobe. It generalises the fixed 32-bit transmitter with configurable width, stop bits, optional parity and a back-pressure handshake.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_frame.sv | 114 +++++++++++
 rtl/uart_word_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word transmitter.
// Parity support is compiled in with `define UART_TX_PARITY_EN.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity when odd == 0, odd parity when odd == 1.
    function automatic logic parity_bit(input logic [UART_BYTE_W-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Serialises one byte as start / 8 data bits LSB first / [parity] / stop bits on baud_tick.
// Parity bit present only with `define UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   baud_tick,
    input  logic                   go,
    input  logic [UART_BYTE_W-1:0] data,
    output logic                   tx,
    output logic                   frame_done
);

    uart_state_e            state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;
    logic                   tx_q, tx_d;
    logic                   last_stop;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        byte_d     = byte_q;
        frame_done = 1'b0;
        last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d = START;
                        byte_d  = data;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
                DATA: begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
`endif
                STOP: begin
                    if (last_stop) begin
                        frame_done = 1'b1;
                        // Chaining straight into the next start bit keeps frames gap-free.
                        if (go) begin
                            state_d = START;
                            byte_d  = data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_bit(byte_d, 1'(PARITY_ODD));
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: valid/ready intake, bytes sent LSB first as back-to-back frames.
// Optional parity bit per frame with `define UART_TX_PARITY_EN.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  baud_tick,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    output logic                  tx,
    output logic                  busy
);

    localparam int NUM_BYTES = WORD_WIDTH / UART_BYTE_W;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    if (WORD_WIDTH < UART_BYTE_W || (WORD_WIDTH % UART_BYTE_W) != 0 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_word_tx: unsupported parameter combination");
    end

    // START here means "frame engine active"; the bit-level states live in uart_tx_frame.
    uart_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic                   busy_q, busy_d;
    logic                   go;
    logic                   frame_done;
    logic [UART_BYTE_W-1:0] frame_data;

    assign s_ready = (state_q == IDLE) && en;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        go         = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    word_d     = s_data;
                    byte_idx_d = '0;
                    state_d    = SYNC;
                    busy_d     = 1'b1;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    go      = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (frame_done) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        go         = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        frame_data = word_q[UART_BYTE_W*byte_idx_d +: UART_BYTE_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    uart_tx_frame #(
        .STOP_BITS (STOP_BITS)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(PARITY_ODD)
`endif
    ) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .go        (go),
        .data      (frame_data),
        .tx        (tx),
        .frame_done(frame_done)
    );

    assign busy = busy_q;

endmodule
